// File: rtl/cm0_mem_pkg.sv
// Shared encodings for the Cortex-M0 memory responder: access sizes and FSM states.
package cm0_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cm0_mem_lane_align.sv
// Combinational byte-lane steering: byte enables, store-data replication, load extraction.
module cm0_mem_lane_align
  import cm0_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_out
);

  logic [1:0] offset;

  // Misaligned low bits are dropped here; faulting them is the caller's job.
  always_comb begin
    offset      = 2'b00;
    be          = 4'b0000;
    wdata_lanes = wdata;
    rdata_out   = 32'd0;
    case (size)
      SIZE_BYTE: begin
        offset      = addr_lo;
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_out   = {24'd0, rdata_word[8*offset +: 8]};
      end
      SIZE_HALF: begin
        offset      = {addr_lo[1], 1'b0};
        be          = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_out   = {16'd0, rdata_word[8*offset +: 16]};
      end
      SIZE_WORD: begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        rdata_out   = rdata_word;
      end
      default: begin
        be        = 4'b0000;
        rdata_out = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/cm0_mem_responder.sv
// Wait-stated word RAM responder for the M0 fetch/load/store bus.
// Define CM0_MEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses.
module cm0_mem_responder
  import cm0_mem_pkg::*;
#(
  parameter int    ADDR_W      = 12,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << (ADDR_W - 2);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic              write_reg;
  logic [31:0]       wdata_reg;

  logic [31:0] mem [0:DEPTH-1];

  // With zero wait states the access happens on the accept edge, so it must use the live request.
  logic              in_idle;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_size;
  logic              acc_write;
  logic [31:0]       acc_wdata;
  logic [31:0]       rd_word;
  logic [3:0]        be;
  logic [31:0]       wdata_lanes;
  logic [31:0]       ld_data;
  logic              req_fault;
  logic              do_access;

  assign in_idle   = (state_reg == ST_IDLE);
  assign acc_addr  = in_idle ? req_addr[ADDR_W-1:0] : addr_reg;
  assign acc_size  = in_idle ? req_size  : size_reg;
  assign acc_write = in_idle ? req_write : write_reg;
  assign acc_wdata = in_idle ? req_wdata : wdata_reg;
  assign rd_word   = mem[acc_addr[ADDR_W-1:2]];

  always_comb begin
    req_fault = (req_size == SIZE_RSVD) || (req_addr[31:ADDR_W] != '0);
`ifdef CM0_MEM_ALIGN_CHECK_EN
    if (req_size == SIZE_HALF && req_addr[0])
      req_fault = 1'b1;
    if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
      req_fault = 1'b1;
`endif
  end

  assign do_access = (in_idle && req_valid && !req_fault && (WAIT_CYCLES == 0))
                   || ((state_reg == ST_WAIT) && (cnt_reg == 4'd0));

  cm0_mem_lane_align u_lane_align (
    .size        (acc_size),
    .addr_lo     (acc_addr[1:0]),
    .wdata       (acc_wdata),
    .rdata_word  (rd_word),
    .be          (be),
    .wdata_lanes (wdata_lanes),
    .rdata_out   (ld_data)
  );

  // RAM has no reset; rst gating keeps a reset-time edge from committing a store.
  always_ff @(posedge clk) begin
    if (do_access && acc_write && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[acc_addr[ADDR_W-1:2]][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      addr_reg   <= '0;
      size_reg   <= SIZE_BYTE;
      write_reg  <= 1'b0;
      wdata_reg  <= 32'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            addr_reg  <= req_addr[ADDR_W-1:0];
            size_reg  <= req_size;
            write_reg <= req_write;
            wdata_reg <= req_wdata;
            req_ready <= 1'b0;
            if (req_fault) begin
              state_reg  <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (WAIT_CYCLES == 0) begin
              state_reg  <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= req_write ? 32'd0 : ld_data;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg  <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write_reg ? 32'd0 : ld_data;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_reg  <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cm0_mem_responder.sv
// Directed bench: two responders (1 and 3 wait states) driven by the same request stream.
module tb_cm0_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_ready = 1'b1;

  logic        req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;
  logic        req_ready3, resp_valid3, resp_err3;
  logic [31:0] resp_rdata3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd1, rd3;
  logic        er1, er3;
  int          l1, l3;

  always #5 clk = ~clk;

  cm0_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  cm0_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid3), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata3), .resp_err(resp_err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request to both DUTs and collect each response and its latency in edges.
  task automatic xact(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic d1, d3;
    @(negedge clk);
    req_write = w; req_size = sz; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    d1 = 1'b0; d3 = 1'b0; l1 = 0; l3 = 0;
    rd1 = 32'hx; rd3 = 32'hx; er1 = 1'bx; er3 = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      if (!d1 && resp_valid1) begin d1 = 1'b1; l1 = c; rd1 = resp_rdata1; er1 = resp_err1; end
      if (!d3 && resp_valid3) begin d3 = 1'b1; l3 = c; rd3 = resp_rdata3; er3 = resp_err3; end
      if (d1 && d3) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd1, input logic [31:0] exp_rd3,
                     input logic exp_er, input int exp_l1, input int exp_l3);
    xact(w, sz, a, d);
    $display("xact %s: w=%0d size=%0d addr=%h wdata=%h -> dut1 %h err=%0d lat=%0d | dut3 %h err=%0d lat=%0d",
             tag, w, sz, a, d, rd1, er1, l1, rd3, er3, l3);
    chk({tag, "/rdata1"}, rd1, exp_rd1);
    chk({tag, "/err1"}, 32'(er1), 32'(exp_er));
    chk({tag, "/lat1"}, 32'(l1), 32'(exp_l1));
    chk({tag, "/rdata3"}, rd3, exp_rd3);
    chk({tag, "/err3"}, 32'(er3), 32'(exp_er));
    chk({tag, "/lat3"}, 32'(l3), 32'(exp_l3));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/req_ready1"}, 32'(req_ready1), 32'd1);
    chk({tag, "/resp_valid1"}, 32'(resp_valid1), 32'd0);
    chk({tag, "/resp_rdata1"}, resp_rdata1, 32'd0);
    chk({tag, "/resp_err1"}, 32'(resp_err1), 32'd0);
    chk({tag, "/req_ready3"}, 32'(req_ready3), 32'd1);
    chk({tag, "/resp_valid3"}, 32'(resp_valid3), 32'd0);
    chk({tag, "/resp_rdata3"}, resp_rdata3, 32'd0);
    chk({tag, "/resp_err3"}, 32'(resp_err3), 32'd0);
  endtask

  logic [31:0] mis_rd;
  logic        mis_er;
  int          mis_l1, mis_l3;

  initial begin
`ifdef CM0_MEM_ALIGN_CHECK_EN
    mis_rd = 32'd0;        mis_er = 1'b1; mis_l1 = 1; mis_l3 = 1;
`else
    mis_rd = 32'hDEAD55EF; mis_er = 1'b0; mis_l1 = 2; mis_l3 = 4;
`endif

    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset_initial");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run("wr_word_010", 1'b1, 2'b10, 32'h010, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0, 2, 4);
    run("rd_word_010", 1'b0, 2'b10, 32'h010, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 4);
    run("wr_byte_011", 1'b1, 2'b00, 32'h011, 32'h00000055, 32'd0, 32'd0, 1'b0, 2, 4);
    run("rd_half_010", 1'b0, 2'b01, 32'h010, 32'd0, 32'h000055EF, 32'h000055EF, 1'b0, 2, 4);
    run("rd_word_010b", 1'b0, 2'b10, 32'h010, 32'd0, 32'hDEAD55EF, 32'hDEAD55EF, 1'b0, 2, 4);
    run("rd_byte_013", 1'b0, 2'b00, 32'h013, 32'd0, 32'h000000DE, 32'h000000DE, 1'b0, 2, 4);
    run("rd_half_012", 1'b0, 2'b01, 32'h012, 32'd0, 32'h0000DEAD, 32'h0000DEAD, 1'b0, 2, 4);
    run("wr_word_000", 1'b1, 2'b10, 32'h000, 32'h11223344, 32'd0, 32'd0, 1'b0, 2, 4);
    run("rd_oob_1000", 1'b0, 2'b10, 32'h1000, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1);
    run("wr_oob_1000", 1'b1, 2'b10, 32'h1000, 32'h12345678, 32'd0, 32'd0, 1'b1, 1, 1);
    run("rd_word_000", 1'b0, 2'b10, 32'h000, 32'd0, 32'h11223344, 32'h11223344, 1'b0, 2, 4);
    run("rd_rsvd_010", 1'b0, 2'b11, 32'h010, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1);
    run("rd_mis_012", 1'b0, 2'b10, 32'h012, 32'd0, mis_rd, mis_rd, mis_er, mis_l1, mis_l3);

    // Reset during WAIT: dut1 has already committed its store, dut3 must discard it.
    run("wr_word_020", 1'b1, 2'b10, 32'h020, 32'hA5A5A5A5, 32'd0, 32'd0, 1'b0, 2, 4);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h020; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstwait/accept_valid1", 32'(resp_valid1), 32'd0);
    chk("rstwait/accept_ready3", 32'(req_ready3), 32'd0);
    @(posedge clk); #1;
    chk("rstwait/resp_valid1", 32'(resp_valid1), 32'd1);
    chk("rstwait/wait_valid3", 32'(resp_valid3), 32'd0);
    rst = 1'b1;
    #1 chk_reset_outputs("rstwait");
    $display("xact rst_in_wait: store CAFEF00D to 020 interrupted");
    @(negedge clk);
    rst = 1'b0;
    run("rd_word_020", 1'b0, 2'b10, 32'h020, 32'd0, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b0, 2, 4);

    // Stall in RESP with resp_ready low, then asynchronous reset mid-response.
    resp_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_addr = 32'h010; req_wdata = 32'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid1 && resp_valid3) break;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      $display("xact stall cycle %0d: v1=%0d d1=%h e1=%0d v3=%0d d3=%h e3=%0d",
               c, resp_valid1, resp_rdata1, resp_err1, resp_valid3, resp_rdata3, resp_err3);
      chk("stall/valid1", 32'(resp_valid1), 32'd1);
      chk("stall/rdata1", resp_rdata1, 32'hDEAD55EF);
      chk("stall/err1", 32'(resp_err1), 32'd0);
      chk("stall/req_ready1", 32'(req_ready1), 32'd0);
      chk("stall/valid3", 32'(resp_valid3), 32'd1);
      chk("stall/rdata3", resp_rdata3, 32'hDEAD55EF);
      chk("stall/err3", 32'(resp_err3), 32'd0);
      chk("stall/req_ready3", 32'(req_ready3), 32'd0);
    end
    rst = 1'b1;
    #1 chk_reset_outputs("reset_midsim");
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    run("rd_word_000b", 1'b0, 2'b10, 32'h000, 32'd0, 32'h11223344, 32'h11223344, 1'b0, 2, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
